// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
// Single-port memory responder with an internal word RAM, a fixed number of
// wait states before each response, and RISC-V style fault reporting for
// misaligned and out-of-range accesses.
//
// Parameters
//   ram_depth   : number of 32-bit RAM words (power of two, >= 4)
//   base_addr   : byte address of RAM word 0 (aligned to 4*ram_depth)
//   wait_cycles : wait states inserted before each response (0..15)
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   rst        : asynchronous active-high reset
//   mem_valid  : request present, held stable by the initiator until mem_ready
//   mem_instr  : request is an instruction fetch
//   mem_addr   : byte address
//   mem_wdata  : store data
//   mem_wstrb  : byte-lane write enables (non-zero means store)
//   mem_ready  : one-cycle response strobe
//   mem_rdata  : load/fetch data, valid while mem_ready is high
//   mem_error  : response is an access or misalignment fault
//   mem_ecause : RISC-V exception cause, valid while mem_error is high
//   mem_etval  : faulting address, valid while mem_error is high
// -----------------------------------------------------------------------------
module mem_responder #(
    parameter int unsigned ram_depth   = 1024,
    parameter logic [31:0] base_addr   = 32'h0000_0000,
    parameter int unsigned wait_cycles = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    input  logic        mem_instr,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        mem_error,
    output logic [3:0]  mem_ecause,
    output logic [31:0] mem_etval
);

    localparam int unsigned IDX_W     = $clog2(ram_depth);
    localparam logic [31:0] RAM_BYTES = 32'(4 * ram_depth);
    localparam bit          NO_WAIT   = (wait_cycles == 0);
    // Guarded so that wait_cycles=0 never evaluates a negative preset.
    localparam logic [3:0]  WAIT_INIT = NO_WAIT ? 4'd0 : 4'(wait_cycles - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q,   cnt_d;
    logic        instr_q, instr_d;
    logic [31:0] addr_q,  addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;

    logic [31:0] ram_q [ram_depth];

    logic [31:0]      offset_s;
    logic [IDX_W-1:0] idx_s;
    logic             is_store_s;
    logic             is_fetch_s;
    logic             misalign_s;
    logic             out_range_s;
    logic             err_s;
    logic [3:0]       cause_s;
    logic             ram_we_s;

    // Request classification and fault decode, from latched request only.
    always_comb begin
        offset_s    = addr_q - base_addr;
        idx_s       = offset_s[IDX_W+1:2];
        is_store_s  = (wstrb_q != 4'b0000);
        is_fetch_s  = instr_q & ~is_store_s;
        misalign_s  = (addr_q[1:0] != 2'b00);
        // Unsigned compare: addresses below base_addr wrap to huge offsets.
        out_range_s = (offset_s >= RAM_BYTES);
        err_s       = misalign_s | out_range_s;
        cause_s     = 4'd0;
        if (misalign_s) begin
            if (is_store_s) begin
                cause_s = 4'd6;
            end else if (is_fetch_s) begin
                cause_s = 4'd0;
            end else begin
                cause_s = 4'd4;
            end
        end else if (out_range_s) begin
            if (is_store_s) begin
                cause_s = 4'd7;
            end else if (is_fetch_s) begin
                cause_s = 4'd1;
            end else begin
                cause_s = 4'd5;
            end
        end else begin
            cause_s = 4'd0;
        end
        // Write fires at the edge ending RESP; reset forces IDLE, so an
        // aborted transaction can never reach this.
        ram_we_s = (state_q == RESP) & is_store_s & ~err_s;
    end

    // Next-state and request-latch logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        instr_d = instr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        case (state_q)
            IDLE: begin
                if (mem_valid) begin
                    instr_d = mem_instr;
                    addr_d  = mem_addr;
                    wdata_d = mem_wdata;
                    wstrb_d = mem_wstrb;
                    cnt_d   = WAIT_INIT;
                    if (NO_WAIT) begin
                        state_d = RESP;
                    end else begin
                        state_d = BUSY;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // State, counter and latched request registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            instr_q <= 1'b0;
            addr_q  <= 32'h0000_0000;
            wdata_q <= 32'h0000_0000;
            wstrb_q <= 4'b0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            instr_q <= instr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
        end
    end

    // RAM byte-lane write; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (ram_we_s) begin
            for (int n = 0; n < 4; n++) begin
                if (wstrb_q[n]) begin
                    ram_q[idx_s][8*n +: 8] <= wdata_q[8*n +: 8];
                end
            end
        end
    end

    // Response outputs, decoded purely from registered state; zero outside RESP.
    always_comb begin
        mem_ready  = 1'b0;
        mem_rdata  = 32'h0000_0000;
        mem_error  = 1'b0;
        mem_ecause = 4'd0;
        mem_etval  = 32'h0000_0000;
        if (state_q == RESP) begin
            mem_ready = 1'b1;
            if (err_s) begin
                mem_error  = 1'b1;
                mem_ecause = cause_s;
                mem_etval  = addr_q;
            end else if (!is_store_s) begin
                mem_rdata = ram_q[idx_s];
            end else begin
                mem_rdata = 32'h0000_0000;
            end
        end else begin
            mem_ready = 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Index 0: wait_cycles=1, depth 1024, base 0
    // Index 1: wait_cycles=0, depth 16,   base 0x1000
    // Index 2: wait_cycles=3, depth 1024, base 0
    logic        valid  [3];
    logic        instr  [3];
    logic [31:0] addr   [3];
    logic [31:0] wdata  [3];
    logic [3:0]  wstrb  [3];
    logic        ready  [3];
    logic [31:0] rdata  [3];
    logic        error  [3];
    logic [3:0]  ecause [3];
    logic [31:0] etval  [3];

    int tests_run    = 0;
    int tests_failed = 0;

    mem_responder #(.ram_depth(1024), .base_addr(32'h0000_0000), .wait_cycles(1)) dut_w1 (
        .clk(clk), .rst(rst), .mem_valid(valid[0]), .mem_instr(instr[0]), .mem_addr(addr[0]),
        .mem_wdata(wdata[0]), .mem_wstrb(wstrb[0]), .mem_ready(ready[0]), .mem_rdata(rdata[0]),
        .mem_error(error[0]), .mem_ecause(ecause[0]), .mem_etval(etval[0]));

    mem_responder #(.ram_depth(16), .base_addr(32'h0000_1000), .wait_cycles(0)) dut_w0 (
        .clk(clk), .rst(rst), .mem_valid(valid[1]), .mem_instr(instr[1]), .mem_addr(addr[1]),
        .mem_wdata(wdata[1]), .mem_wstrb(wstrb[1]), .mem_ready(ready[1]), .mem_rdata(rdata[1]),
        .mem_error(error[1]), .mem_ecause(ecause[1]), .mem_etval(etval[1]));

    mem_responder #(.ram_depth(1024), .base_addr(32'h0000_0000), .wait_cycles(3)) dut_w3 (
        .clk(clk), .rst(rst), .mem_valid(valid[2]), .mem_instr(instr[2]), .mem_addr(addr[2]),
        .mem_wdata(wdata[2]), .mem_wstrb(wstrb[2]), .mem_ready(ready[2]), .mem_rdata(rdata[2]),
        .mem_error(error[2]), .mem_ecause(ecause[2]), .mem_etval(etval[2]));

    // Drives one request, waits (bounded) for mem_ready, returns the response.
    // lat counts negedges after the accepting edge (-1 on timeout); stray is
    // set if any response output was non-zero while mem_ready was low.
    task automatic do_req(input int id, input logic f_instr, input logic [31:0] f_addr,
                          input logic [31:0] f_wdata, input logic [3:0] f_wstrb, input bit scramble,
                          output int lat, output logic [31:0] r_rdata, output logic r_err,
                          output logic [3:0] r_ec, output logic [31:0] r_etval, output bit stray);
        lat = -1; stray = 1'b0;
        r_rdata = 32'h0; r_err = 1'b0; r_ec = 4'h0; r_etval = 32'h0;
        @(negedge clk);
        valid[id] = 1'b1; instr[id] = f_instr; addr[id] = f_addr;
        wdata[id] = f_wdata; wstrb[id] = f_wstrb;
        @(posedge clk);
        if (scramble) begin
            #1;
            valid[id] = 1'b0; instr[id] = ~f_instr; addr[id] = ~f_addr;
            wdata[id] = ~f_wdata; wstrb[id] = ~f_wstrb;
        end
        for (int i = 1; i <= 24; i++) begin
            @(negedge clk);
            if (ready[id] === 1'b1) begin
                lat = i; r_rdata = rdata[id]; r_err = error[id];
                r_ec = ecause[id]; r_etval = etval[id];
                break;
            end else if (rdata[id] !== 32'h0 || error[id] !== 1'b0 ||
                         ecause[id] !== 4'h0 || etval[id] !== 32'h0) begin
                stray = 1'b1;
            end
        end
        valid[id] = 1'b0; instr[id] = 1'b0; addr[id] = 32'h0;
        wdata[id] = 32'h0; wstrb[id] = 4'h0;
    endtask

    int          lat;
    logic [31:0] rd, etv;
    logic        er;
    logic [3:0]  ec;
    bit          st;

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            valid[i] = 1'b0; instr[i] = 1'b0; addr[i] = 32'h0; wdata[i] = 32'h0; wstrb[i] = 4'h0;
        end
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if (ready[i] !== 1'b0 || rdata[i] !== 32'h0 || error[i] !== 1'b0 ||
                ecause[i] !== 4'h0 || etval[i] !== 32'h0) begin
                tests_failed++;
                $display("FAIL reset_outputs[%0d]: ready=%b rdata=%h err=%b ec=%0d etval=%h, want all 0",
                         i, ready[i], rdata[i], error[i], ecause[i], etval[i]);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_store_load();
        do_req(0, 1'b0, 32'h10, 32'hDEAD_BEEF, 4'b1111, 1'b0, lat, rd, er, ec, etv, st);
        tests_run++;
        if (lat !== 2 || rd !== 32'h0 || er !== 1'b0 || ec !== 4'h0 || etv !== 32'h0 || st) begin
            tests_failed++;
            $display("FAIL store_full: lat=%0d rdata=%h err=%b ec=%0d etval=%h stray=%b, want lat=2 rdata=0 err=0 ec=0 etval=0 stray=0",
                     lat, rd, er, ec, etv, st);
        end
        do_req(0, 1'b0, 32'h10, 32'h0, 4'b0000, 1'b0, lat, rd, er, ec, etv, st);
        tests_run++;
        if (lat !== 2 || rd !== 32'hDEAD_BEEF || er !== 1'b0 || ec !== 4'h0 || etv !== 32'h0 || st) begin
            tests_failed++;
            $display("FAIL load_full: lat=%0d rdata=%h err=%b ec=%0d etval=%h stray=%b, want lat=2 rdata=deadbeef err=0",
                     lat, rd, er, ec, etv, st);
        end
    endtask

    task automatic test_byte_lanes();
        do_req(0, 1'b0, 32'h10, 32'h0000_00AA, 4'b0001, 1'b0, lat, rd, er, ec, etv, st);
        do_req(0, 1'b0, 32'h10, 32'h0, 4'b0000, 1'b0, lat, rd, er, ec, etv, st);
        tests_run++;
        if (lat !== 2 || rd !== 32'hDEAD_BEAA || er !== 1'b0) begin
            tests_failed++;
            $display("FAIL lane0_store: lat=%0d rdata=%h err=%b, want lat=2 rdata=deadbeaa err=0", lat, rd, er);
        end
        do_req(0, 1'b0, 32'h10, 32'h1122_3344, 4'b1010, 1'b0, lat, rd, er, ec, etv, st);
        do_req(0, 1'b0, 32'h10, 32'h0, 4'b0000, 1'b0, lat, rd, er, ec, etv, st);
        tests_run++;
        if (rd !== 32'h11AD_33AA || er !== 1'b0) begin
            tests_failed++;
            $display("FAIL lane31_store: rdata=%h err=%b, want rdata=11ad33aa err=0", rd, er);
        end
        do_req(0, 1'b1, 32'h10, 32'h0, 4'b0000, 1'b0, lat, rd, er, ec, etv, st);
        tests_run++;
        if (lat !== 2 || rd !== 32'h11AD_33AA || er !== 1'b0 || ec !== 4'h0) begin
            tests_failed++;
            $display("FAIL fetch_good: lat=%0d rdata=%h err=%b ec=%0d, want lat=2 rdata=11ad33aa err=0 ec=0", lat, rd, er, ec);
        end
        // Request fields trashed right after acceptance must not matter.
        do_req(0, 1'b0, 32'h10, 32'h0, 4'b0000, 1'b1, lat, rd, er, ec, etv, st);
        tests_run++;
        if (lat !== 2 || rd !== 32'h11AD_33AA || er !== 1'b0) begin
            tests_failed++;
            $display("FAIL late_change: lat=%0d rdata=%h err=%b, want lat=2 rdata=11ad33aa err=0", lat, rd, er);
        end
    endtask

    task automatic test_range();
        do_req(0, 1'b0, 32'h0, 32'h1234_5678, 4'b1111, 1'b0, lat, rd, er, ec, etv, st);
        do_req(0, 1'b0, 32'h1000, 32'h0, 4'b0000, 1'b0, lat, rd, er, ec, etv, st);
        tests_run++;
        if (lat !== 2 || er !== 1'b1 || ec !== 4'd5 || etv !== 32'h1000 || rd !== 32'h0) begin
            tests_failed++;
            $display("FAIL range_load: lat=%0d err=%b ec=%0d etval=%h rdata=%h, want lat=2 err=1 ec=5 etval=1000 rdata=0",
                     lat, er, ec, etv, rd);
        end
        do_req(0, 1'b1, 32'h1000, 32'h0, 4'b0000, 1'b0, lat, rd, er, ec, etv, st);
        tests_run++;
        if (er !== 1'b1 || ec !== 4'd1 || etv !== 32'h1000) begin
            tests_failed++;
            $display("FAIL range_fetch: err=%b ec=%0d etval=%h, want err=1 ec=1 etval=1000", er, ec, etv);
        end
        do_req(0, 1'b0, 32'h1000, 32'hFFFF_FFFF, 4'b1111, 1'b0, lat, rd, er, ec, etv, st);
        tests_run++;
        if (er !== 1'b1 || ec !== 4'd7 || etv !== 32'h1000 || rd !== 32'h0) begin
            tests_failed++;
            $display("FAIL range_store: err=%b ec=%0d etval=%h rdata=%h, want err=1 ec=7 etval=1000 rdata=0", er, ec, etv, rd);
        end
        // 0x1000 aliases word 0 if the index were simply truncated.
        do_req(0, 1'b0, 32'h0, 32'h0, 4'b0000, 1'b0, lat, rd, er, ec, etv, st);
        tests_run++;
        if (rd !== 32'h1234_5678 || er !== 1'b0) begin
            tests_failed++;
            $display("FAIL range_nowrite: rdata=%h err=%b, want rdata=12345678 err=0", rd, er);
        end
        do_req(0, 1'b0, 32'hFFC, 32'hA5A5_5A5A, 4'b1111, 1'b0, lat, rd, er, ec, etv, st);
        do_req(0, 1'b0, 32'hFFC, 32'h0, 4'b0000, 1'b0, lat, rd, er, ec, etv, st);
        tests_run++;
        if (rd !== 32'hA5A5_5A5A || er !== 1'b0) begin
            tests_failed++;
            $display("FAIL last_word: rdata=%h err=%b, want rdata=a5a55a5a err=0", rd, er);
        end
    endtask

    task automatic test_misalign();
        do_req(0, 1'b0, 32'h2, 32'h0, 4'b0000, 1'b0, lat, rd, er, ec, etv, st);
        tests_run++;
        if (er !== 1'b1 || ec !== 4'd4 || etv !== 32'h2 || rd !== 32'h0) begin
            tests_failed++;
            $display("FAIL misalign_load: err=%b ec=%0d etval=%h rdata=%h, want err=1 ec=4 etval=2 rdata=0", er, ec, etv, rd);
        end
        do_req(0, 1'b0, 32'h2, 32'hFFFF_FFFF, 4'b1111, 1'b0, lat, rd, er, ec, etv, st);
        tests_run++;
        if (er !== 1'b1 || ec !== 4'd6 || etv !== 32'h2) begin
            tests_failed++;
            $display("FAIL misalign_store: err=%b ec=%0d etval=%h, want err=1 ec=6 etval=2", er, ec, etv);
        end
        do_req(0, 1'b1, 32'h1, 32'h0, 4'b0000, 1'b0, lat, rd, er, ec, etv, st);
        tests_run++;
        if (er !== 1'b1 || ec !== 4'd0 || etv !== 32'h1) begin
            tests_failed++;
            $display("FAIL misalign_fetch: err=%b ec=%0d etval=%h, want err=1 ec=0 etval=1", er, ec, etv);
        end
        do_req(0, 1'b0, 32'h0, 32'h0, 4'b0000, 1'b0, lat, rd, er, ec, etv, st);
        tests_run++;
        if (rd !== 32'h1234_5678 || er !== 1'b0) begin
            tests_failed++;
            $display("FAIL misalign_nowrite: rdata=%h err=%b, want rdata=12345678 err=0", rd, er);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] seen;
        seen = 8'h00;
        @(negedge clk);
        valid[1] = 1'b1; instr[1] = 1'b0; addr[1] = 32'h1004; wdata[1] = 32'h0000_0055; wstrb[1] = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            seen[i] = ready[1];
        end
        valid[1] = 1'b0; wstrb[1] = 4'h0; wdata[1] = 32'h0; addr[1] = 32'h0;
        tests_run++;
        if (seen !== 8'b0101_0101) begin
            tests_failed++;
            $display("FAIL b2b_pattern: ready history=%b, want 01010101", seen);
        end
        do_req(1, 1'b0, 32'h1004, 32'h0, 4'b0000, 1'b0, lat, rd, er, ec, etv, st);
        tests_run++;
        if (lat !== 1 || rd !== 32'h0000_0055 || er !== 1'b0) begin
            tests_failed++;
            $display("FAIL w0_load: lat=%0d rdata=%h err=%b, want lat=1 rdata=55 err=0", lat, rd, er);
        end
        do_req(1, 1'b0, 32'h1040, 32'h0, 4'b0000, 1'b0, lat, rd, er, ec, etv, st);
        tests_run++;
        if (er !== 1'b1 || ec !== 4'd5 || etv !== 32'h1040) begin
            tests_failed++;
            $display("FAIL w0_above_range: err=%b ec=%0d etval=%h, want err=1 ec=5 etval=1040", er, ec, etv);
        end
        do_req(1, 1'b0, 32'h0FFC, 32'h0, 4'b0000, 1'b0, lat, rd, er, ec, etv, st);
        tests_run++;
        if (er !== 1'b1 || ec !== 4'd5 || etv !== 32'h0FFC) begin
            tests_failed++;
            $display("FAIL w0_below_base: err=%b ec=%0d etval=%h, want err=1 ec=5 etval=ffc", er, ec, etv);
        end
    endtask

    task automatic test_reset_abort();
        int pulses;
        do_req(2, 1'b0, 32'h8, 32'hCAFE_F00D, 4'b1111, 1'b0, lat, rd, er, ec, etv, st);
        tests_run++;
        if (lat !== 4 || er !== 1'b0 || st) begin
            tests_failed++;
            $display("FAIL w3_store: lat=%0d err=%b stray=%b, want lat=4 err=0 stray=0", lat, er, st);
        end
        // Abort during the second BUSY cycle.
        @(negedge clk);
        valid[2] = 1'b1; addr[2] = 32'h8; wdata[2] = 32'h0BAD_BEEF; wstrb[2] = 4'b1111;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        valid[2] = 1'b0; addr[2] = 32'h0; wdata[2] = 32'h0; wstrb[2] = 4'h0;
        #1;
        tests_run++;
        if (ready[2] !== 1'b0 || rdata[2] !== 32'h0 || error[2] !== 1'b0 || etval[2] !== 32'h0) begin
            tests_failed++;
            $display("FAIL abort_busy_outputs: ready=%b rdata=%h err=%b etval=%h, want all 0",
                     ready[2], rdata[2], error[2], etval[2]);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        // Abort while the response is being presented: outputs drop immediately.
        @(negedge clk);
        valid[2] = 1'b1; addr[2] = 32'h8; wdata[2] = 32'h0BAD_BEEF; wstrb[2] = 4'b1111;
        pulses = 0;
        for (int i = 0; i < 12 && pulses == 0; i++) begin
            @(negedge clk);
            if (ready[2] === 1'b1) pulses = 1;
        end
        #1 rst = 1'b1;
        valid[2] = 1'b0; addr[2] = 32'h0; wdata[2] = 32'h0; wstrb[2] = 4'h0;
        #1;
        tests_run++;
        if (pulses !== 1 || ready[2] !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_resp_outputs: saw_resp=%0d ready_after_rst=%b, want 1 and 0", pulses, ready[2]);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ready[2] === 1'b1) pulses++;
        end
        tests_run++;
        if (pulses !== 0) begin
            tests_failed++;
            $display("FAIL abort_no_pulse: ready pulses=%0d, want 0", pulses);
        end
        do_req(2, 1'b0, 32'h8, 32'h0, 4'b0000, 1'b0, lat, rd, er, ec, etv, st);
        tests_run++;
        if (lat !== 4 || rd !== 32'hCAFE_F00D || er !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_old_data: lat=%0d rdata=%h err=%b, want lat=4 rdata=cafef00d err=0", lat, rd, er);
        end
        // Word 0x10 on the wait_cycles=1 instance must survive the resets.
        do_req(0, 1'b0, 32'h10, 32'h0, 4'b0000, 1'b0, lat, rd, er, ec, etv, st);
        tests_run++;
        if (rd !== 32'h11AD_33AA || er !== 1'b0) begin
            tests_failed++;
            $display("FAIL ram_kept: rdata=%h err=%b, want rdata=11ad33aa err=0", rd, er);
        end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_byte_lanes();
        test_range();
        test_misalign();
        test_back_to_back();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
